// File: rtl/control_cond_logic.sv
// Conditional-execution stage: holds NZCV flags, evaluates the condition field, gates side effects.
// Optional squashed-instruction counter is built when COND_STATS_EN is defined.
module control_cond_logic #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [3:0]       cond,
   input  logic [3:0]       aluflags,
   input  logic [1:0]       flagw,
   input  logic             pcs,
   input  logic             regw,
   input  logic             memw,
   output logic             pcsrc,
   output logic             regwrite,
   output logic             memwrite,
   output logic [3:0]       flags,
   output logic             condex,
   output logic             illegal,
   output logic [CNT_W-1:0] squash_cnt
);

   logic [3:0] flags_r;
   logic       condex_s;
   logic       illegal_s;

   // Evaluates one condition code against {N,Z,C,V}; 4'b1111 never passes.
   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n;
      logic z;
      logic cf;
      logic v;
      logic p;
      n  = f[3];
      z  = f[2];
      cf = f[1];
      v  = f[0];
      case (c)
         4'b0000: p = z;
         4'b0001: p = ~z;
         4'b0010: p = cf;
         4'b0011: p = ~cf;
         4'b0100: p = n;
         4'b0101: p = ~n;
         4'b0110: p = v;
         4'b0111: p = ~v;
         4'b1000: p = cf & ~z;
         4'b1001: p = ~cf | z;
         4'b1010: p = (n == v);
         4'b1011: p = (n != v);
         4'b1100: p = ~z & (n == v);
         4'b1101: p = z | (n != v);
         4'b1110: p = 1'b1;
         default: p = 1'b0;
      endcase
      return p;
   endfunction

   // Condition check reads only the registered flags, so same-cycle flag writes are not seen.
   always_comb begin
      condex_s  = cond_pass(cond, flags_r);
      if (cond == 4'b1111) begin
         illegal_s = en;
      end else begin
         illegal_s = 1'b0;
      end
   end

   // Flag halves load independently, only for an advancing instruction whose condition passed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_r <= 4'b0000;
      end else if (en && condex_s) begin
         if (flagw[1]) begin
            flags_r[3:2] <= aluflags[3:2];
         end
         if (flagw[0]) begin
            flags_r[1:0] <= aluflags[1:0];
         end
      end
   end

   assign condex   = condex_s;
   assign illegal  = illegal_s;
   assign flags    = flags_r;
   assign pcsrc    = pcs  & condex_s & en;
   assign regwrite = regw & condex_s & en;
   assign memwrite = memw & condex_s & en;

`ifdef COND_STATS_EN
   logic             squash_s;
   logic [CNT_W-1:0] squash_cnt_r;

   assign squash_s = en & ~condex_s & (pcs | regw | memw | (flagw != 2'b00));

   // Saturating count of instructions that wanted a side effect but were suppressed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         squash_cnt_r <= {CNT_W{1'b0}};
      end else if (squash_s && (squash_cnt_r != {CNT_W{1'b1}})) begin
         squash_cnt_r <= squash_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign squash_cnt = squash_cnt_r;
`else
   assign squash_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_control_cond_logic.sv
// Directed + random bench for control_cond_logic with a scoreboard queue of expected outputs.
module tb_control_cond_logic;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  cond;
   logic [3:0]  aluflags;
   logic [1:0]  flagw;
   logic        pcs, regw, memw;
   logic        pcsrc, regwrite, memwrite, condex, illegal;
   logic [3:0]  flags;
   logic [15:0] squash_cnt;
   logic        pcsrc2, regwrite2, memwrite2, condex2, illegal2;
   logic [3:0]  flags2;
   logic [1:0]  squash_cnt2;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic        condex;
      logic        illegal;
      logic        pcsrc;
      logic        regwrite;
      logic        memwrite;
      logic [3:0]  flags;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] mflags;
   int         mcnt;

   always #5 clk = ~clk;

   control_cond_logic #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .cond(cond), .aluflags(aluflags), .flagw(flagw),
      .pcs(pcs), .regw(regw), .memw(memw), .pcsrc(pcsrc), .regwrite(regwrite),
      .memwrite(memwrite), .flags(flags), .condex(condex), .illegal(illegal),
      .squash_cnt(squash_cnt)
   );

   control_cond_logic #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .cond(cond), .aluflags(aluflags), .flagw(flagw),
      .pcs(pcs), .regw(regw), .memw(memw), .pcsrc(pcsrc2), .regwrite(regwrite2),
      .memwrite(memwrite2), .flags(flags2), .condex(condex2), .illegal(illegal2),
      .squash_cnt(squash_cnt2)
   );

   // Pairs of conditions share a base test; the odd code is its inverse.
   function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
      logic base;
      if (c == 4'hF) return 1'b0;
      if (c == 4'hE) return 1'b1;
      case (c[3:1])
         3'd0: base = f[2];
         3'd1: base = f[1];
         3'd2: base = f[3];
         3'd3: base = f[0];
         3'd4: base = f[1] && !f[2];
         3'd5: base = (f[3] == f[0]);
         default: base = !f[2] && (f[3] == f[0]);
      endcase
      return base ^ c[0];
   endfunction

   function automatic logic [15:0] exp_cnt(input int sat);
`ifdef COND_STATS_EN
      return 16'((mcnt > sat) ? sat : mcnt);
`else
      return 16'(sat - sat);
`endif
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out();
      exp_t x;
      x = sb.pop_front();
      chk("condex",     16'(condex),     16'(x.condex));
      chk("illegal",    16'(illegal),    16'(x.illegal));
      chk("pcsrc",      16'(pcsrc),      16'(x.pcsrc));
      chk("regwrite",   16'(regwrite),   16'(x.regwrite));
      chk("memwrite",   16'(memwrite),   16'(x.memwrite));
      chk("flags",      16'(flags),      16'(x.flags));
      chk("squash_cnt", squash_cnt,      x.cnt);
      chk("squash_sat", 16'(squash_cnt2), 16'(x.cnt2));
      chk("flags_w2",   16'(flags2),     16'(x.flags));
   endtask

   task automatic step(input logic e, input logic [3:0] c, input logic [3:0] af,
                       input logic [1:0] fw, input logic p, input logic r, input logic m);
      exp_t x;
      logic pass;
      en = e; cond = c; aluflags = af; flagw = fw; pcs = p; regw = r; memw = m;
      pass       = model_pass(c, mflags);
      x.condex   = pass;
      x.illegal  = e && (c == 4'hF);
      x.pcsrc    = p && pass && e;
      x.regwrite = r && pass && e;
      x.memwrite = m && pass && e;
      x.flags    = mflags;
      x.cnt      = exp_cnt(65535);
      x.cnt2     = 2'(exp_cnt(3));
      sb.push_back(x);
      @(negedge clk);
      check_out();
      @(posedge clk);
      if (e && pass) begin
         if (fw[1]) mflags[3:2] = af[3:2];
         if (fw[0]) mflags[1:0] = af[1:0];
      end
      if (e && !pass && (p || r || m || fw != 2'b00)) mcnt++;
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; cond = 4'h0; aluflags = 4'h0; flagw = 2'b00;
      pcs = 1'b0; regw = 1'b0; memw = 1'b0;
      mflags = 4'h0; mcnt = 0;
      #1;
      chk("reset_flags", 16'(flags), 16'h0000);
      chk("reset_cnt",   squash_cnt, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Flags zero: EQ fails, NE passes
      step(1'b1, 4'b0000, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      step(1'b1, 4'b0001, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      // AL sets flags, then EQ passes and HI fails
      step(1'b1, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'b0000, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      step(1'b1, 4'b1000, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      // Independent flag halves
      step(1'b1, 4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'b1110, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
      // N=1 V=0: LT passes, GE fails and may not touch flags
      step(1'b1, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'b1011, 4'h0, 2'b00, 1'b1, 1'b0, 1'b1);
      step(1'b1, 4'b1010, 4'b0101, 2'b11, 1'b1, 1'b0, 1'b1);
      step(1'b1, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
      // Stall, then illegal condition
      step(1'b0, 4'b1110, 4'b0111, 2'b11, 1'b0, 1'b1, 1'b0);
      step(1'b1, 4'b1111, 4'b0111, 2'b11, 1'b1, 1'b1, 1'b1);
      step(1'b1, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
      // Five more squashes with EQ failing on Z=0
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      step(1'b0, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 48; i++) begin
         step(($urandom_range(3) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
      end

      // Asynchronous reset between edges with nonzero flags
      step(1'b1, 4'b1110, 4'b1011, 2'b11, 1'b0, 1'b0, 1'b0);
      en = 1'b1; cond = 4'b0000; regw = 1'b1; flagw = 2'b00; pcs = 1'b0; memw = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      mflags = 4'h0; mcnt = 0;
      chk("arst_flags",    16'(flags),       16'h0000);
      chk("arst_cnt",      squash_cnt,       16'h0000);
      chk("arst_cnt2",     16'(squash_cnt2), 16'h0000);
      chk("arst_eq",       16'(condex),      16'(model_pass(4'b0000, mflags)));
      chk("arst_regwrite", 16'(regwrite),    16'h0000);
      cond = 4'b0001;
      #1;
      chk("arst_ne", 16'(condex), 16'(model_pass(4'b0001, mflags)));
      cond = 4'b1110;
      #1;
      chk("arst_al", 16'(condex), 16'h0001);
      en = 1'b0; regw = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 4'b0001, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      step(1'b1, 4'b0000, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
